// File: rtl/pzhsbus_pkg.sv
// pzhsbus_pkg: shared constants and helpers for the pzhsbus stream blocks.
//   PZHSBUS_RR_MUX_DEPTH : depth of the round-robin mux output buffer
//   calc_index_width(n)  : width of an index into n items, never below 1
package pzhsbus_pkg;

  localparam int PZHSBUS_RR_MUX_DEPTH = 2;

  function automatic int calc_index_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pzhsbus_rr_mux_arbiter.sv
// pzhsbus_rr_mux_arbiter: combinational round-robin grant logic.
// The search starts at the slave after i_ptr and wraps modulo SLAVES; the
// first requesting slave wins. The pointer register is held by the caller.
// Ports:
//   i_request     [SLAVES]  per-slave request (slave valid)
//   i_enable      1         grant allowed this cycle
//   i_ptr         IDX_W     last granted slave
//   o_grant       [SLAVES]  one-hot grant, all zero when disabled or idle
//   o_grant_index IDX_W     index of the granted slave (0 when no grant)
module pzhsbus_rr_mux_arbiter
  import pzhsbus_pkg::*;
#(
  parameter int SLAVES = 2,
  localparam int IDX_W = calc_index_width(SLAVES)
) (
  input  logic [SLAVES-1:0] i_request,
  input  logic              i_enable,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [SLAVES-1:0] o_grant,
  output logic [IDX_W-1:0]  o_grant_index
);

  localparam int unsigned N = SLAVES;

  int unsigned cand;
  logic        found;

  always_comb begin
    o_grant       = '0;
    o_grant_index = '0;
    found         = 1'b0;
    cand          = '0;
    if (i_enable) begin
      for (int unsigned off = 1; off <= N; off++) begin
        // i_ptr < N, so a single subtraction is enough to wrap
        cand = 32'(i_ptr) + off;
        if (cand >= N) begin
          cand = cand - N;
        end
        if (!found && i_request[cand[IDX_W-1:0]]) begin
          found                        = 1'b1;
          o_grant[cand[IDX_W-1:0]]     = 1'b1;
          o_grant_index                = cand[IDX_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/pzhsbus_rr_mux.sv
// pzhsbus_rr_mux: round-robin merge of SLAVES pzhsbus streams onto one
// master stream, through a registered 2-entry FIFO (1 beat/cycle).
// Slave ready depends only on registered state and slave valid, never on
// master_if_ready.
// Optional feature macro: PZHSBUS_RR_MUX_LOCK_EN adds i_lock[SLAVES]; a push
// from slave k with i_lock[k]=1 keeps slave k at top priority.
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   slave_if_valid/ready/payload [SLAVES]  source streams
//   i_lock [SLAVES]         (PZHSBUS_RR_MUX_LOCK_EN only) hold priority
//   master_if_valid/ready/payload          merged stream
//   o_source                slave index of the head beat
//   o_busy                  buffer non-empty
module pzhsbus_rr_mux
  import pzhsbus_pkg::*;
#(
  parameter type PAYLOAD = logic,
  parameter int  SLAVES  = 2,
  localparam int IDX_W   = calc_index_width(SLAVES)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [SLAVES-1:0] slave_if_valid,
  output logic [SLAVES-1:0] slave_if_ready,
  input  PAYLOAD            slave_if_payload [SLAVES],
`ifdef PZHSBUS_RR_MUX_LOCK_EN
  input  logic [SLAVES-1:0] i_lock,
`endif
  output logic              master_if_valid,
  input  logic              master_if_ready,
  output PAYLOAD            master_if_payload,
  output logic [IDX_W-1:0]  o_source,
  output logic              o_busy
);

  typedef struct packed {
    PAYLOAD             payload;
    logic [IDX_W-1:0]   source;
  } entry_t;

  logic [1:0]        count_q;
  logic [IDX_W-1:0]  ptr_q;
  entry_t            fifo_q [PZHSBUS_RR_MUX_DEPTH];

  logic              acc_en;
  logic [SLAVES-1:0] grant;
  logic [IDX_W-1:0]  grant_index;
  logic [IDX_W-1:0]  next_ptr;
  logic              push;
  logic              pop;
  entry_t            new_entry;

  // Ready is also held low while reset is asserted, so no slave sees a
  // handshake that the buffer will not keep.
  assign acc_en = (count_q < 2'(PZHSBUS_RR_MUX_DEPTH)) && !i_rst;

  pzhsbus_rr_mux_arbiter #(
    .SLAVES (SLAVES)
  ) u_arbiter (
    .i_request     (slave_if_valid),
    .i_enable      (acc_en),
    .i_ptr         (ptr_q),
    .o_grant       (grant),
    .o_grant_index (grant_index)
  );

  assign slave_if_ready = grant;
  assign push           = |grant;
  assign pop            = master_if_valid && master_if_ready;

  always_comb begin
    new_entry.payload = slave_if_payload[grant_index];
    new_entry.source  = grant_index;
  end

  always_comb begin
    next_ptr = grant_index;
`ifdef PZHSBUS_RR_MUX_LOCK_EN
    // Park the pointer just before the locked slave so it is searched first.
    if (i_lock[grant_index]) begin
      next_ptr = (grant_index == '0) ? IDX_W'(SLAVES - 1) : grant_index - IDX_W'(1);
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q   <= '0;
      ptr_q     <= IDX_W'(SLAVES - 1);
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      // push requires count<2 and pop requires count>0, so push+pop only
      // happens at count==1: the new beat replaces the head in place.
      if (push && pop) begin
        fifo_q[0] <= new_entry;
      end else if (pop) begin
        fifo_q[0] <= fifo_q[1];
        count_q   <= count_q - 2'd1;
      end else if (push) begin
        if (count_q == 2'd0) begin
          fifo_q[0] <= new_entry;
        end else begin
          fifo_q[1] <= new_entry;
        end
        count_q <= count_q + 2'd1;
      end
      if (push) begin
        ptr_q <= next_ptr;
      end
    end
  end

  assign master_if_valid   = (count_q != 2'd0);
  assign master_if_payload = fifo_q[0].payload;
  assign o_source          = fifo_q[0].source;
  assign o_busy            = master_if_valid;

  // Slave contract: valid and payload hold until the beat is accepted.
  for (genvar g = 0; g < SLAVES; g++) begin : g_contract
    a_slave_hold: assert property (
      @(posedge i_clk) disable iff (i_rst)
      (slave_if_valid[g] && !slave_if_ready[g]) |=>
        (slave_if_valid[g] && $stable(slave_if_payload[g])));
  end

endmodule
